// File: rtl/decode_writeback_if.sv
// Decode/writeback bundle: instruction fields, execute/memory results,
// decode operands, CC/status and the debug register port.
interface decode_writeback_if #(
  parameter int WIDTH = 64
);
  logic             commit;
  logic [7:0]       opcode;
  logic [7:0]       rArB;
  logic [7:0]       rArB_wb;
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic [2:0]       cc_in;
  logic             mem_error;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [2:0]       cc;
  logic [1:0]       stat;
  logic [3:0]       dbg_sel;
  logic [WIDTH-1:0] dbg_val;

  modport master (
    output commit, opcode, rArB, rArB_wb,
    output valE, valM, cc_in, mem_error,
    output dbg_sel,
    input  valA, valB, cc, stat, dbg_val
  );

  modport slave (
    input  commit, opcode, rArB, rArB_wb,
    input  valE, valM, cc_in, mem_error,
    input  dbg_sel,
    output valA, valB, cc, stat, dbg_val
  );
endinterface

// File: rtl/decode_writeback.sv
// SEQ register file around execute: combinational decode reads,
// clocked writeback of valE/valM, CC register and sticky status.
module decode_writeback #(
  parameter int          WIDTH    = 64,
  parameter logic [3:0]  RSP_ID   = 4'h4,
  parameter logic [2:0]  CC_RESET = 3'b001
) (
  input logic         clk,
  input logic         reset,
  decode_writeback_if.slave bus
);
  typedef enum logic [1:0] {
    AOK = 2'b00,
    HLT = 2'b01,
    INS = 2'b10,
    ADR = 2'b11
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  logic [WIDTH-1:0] regs_q [15];
  logic [WIDTH-1:0] regs_d [15];
  logic [2:0]       cc_q, cc_d;
  stat_e            stat_q, stat_d;

  logic [3:0] icode;
  logic [3:0] ra, rb, ra_wb, rb_wb;
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic       wr_en;
  logic       unused_ifun;

  assign icode       = bus.opcode[7:4];
  assign ra          = bus.rArB[7:4];
  assign rb          = bus.rArB[3:0];
  assign ra_wb       = bus.rArB_wb[7:4];
  assign rb_wb       = bus.rArB_wb[3:0];
  assign unused_ifun = ^bus.opcode[3:0];

  always_comb begin
    src_a = RNONE;
    unique case (1'b1)
      icode inside {4'h2, 4'h4, 4'h6, 4'hA}: src_a = ra;
      icode inside {4'h9, 4'hB}:             src_a = RSP_ID;
      default: ;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    unique case (1'b1)
      icode inside {4'h4, 4'h5, 4'h6}:       src_b = rb;
      icode inside {4'h8, 4'h9, 4'hA, 4'hB}: src_b = RSP_ID;
      default: ;
    endcase
  end

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      icode inside {4'h2, 4'h3, 4'h6}:       dst_e = rb_wb;
      icode inside {4'h8, 4'h9, 4'hA, 4'hB}: dst_e = RSP_ID;
      default: ;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (1'b1)
      icode inside {4'h5, 4'hB}: dst_m = ra_wb;
      default: ;
    endcase
  end

  // Faulting instruction must not commit, so writes wait on stat_d too
  always_comb begin
    stat_d = stat_q;
    if (bus.commit && stat_q == AOK) begin
      priority case (1'b1)
        icode > 4'hB:  stat_d = INS;
        bus.mem_error: stat_d = ADR;
        icode == 4'h0: stat_d = HLT;
        default: ;
      endcase
    end
  end

  assign wr_en = bus.commit && stat_q == AOK && stat_d == AOK;

  // valM assigned last so popq %rsp keeps the popped value
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      if (dst_e != RNONE) regs_d[dst_e] = bus.valE;
      if (dst_m != RNONE) regs_d[dst_m] = bus.valM;
    end
  end

  assign cc_d = (wr_en && icode == 4'h6) ? bus.cc_in : cc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      cc_q   <= CC_RESET;
      stat_q <= AOK;
    end else begin
      regs_q <= regs_d;
      cc_q   <= cc_d;
      stat_q <= stat_d;
    end
  end

  assign bus.valA    = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign bus.valB    = (src_b == RNONE) ? '0 : regs_q[src_b];
  assign bus.dbg_val = (bus.dbg_sel == RNONE) ? '0
                     : regs_q[bus.dbg_sel];
  assign bus.cc      = cc_q;
  assign bus.stat    = stat_q;
endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: spec-level model checked every negedge,
// plus directed vectors with hand-computed register/CC/status values.
module tb_decode_writeback;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_writeback_if #(.WIDTH(W)) bus ();

  decode_writeback #(
    .WIDTH(W),
    .RSP_ID(4'h4),
    .CC_RESET(3'b001)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  logic       pin = 1'b0;
  logic [3:0] pin_sel = 4'h0;
  logic [3:0] rot = 4'h0;
  always @(posedge clk) rot <= rot + 4'h1;
  assign bus.dbg_sel = pin ? pin_sel : rot;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  logic [W-1:0] m_reg [16];
  logic [2:0]   m_cc;
  logic [1:0]   m_stat;

  function automatic logic [W-1:0] m_rd(input logic [3:0] s);
    return (s == 4'hF) ? '0 : m_reg[s];
  endfunction

  function automatic logic [3:0] m_src_a(input logic [3:0] ic,
                                         input logic [3:0] a);
    if (ic inside {2, 4, 6, 10}) return a;
    if (ic inside {9, 11}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic,
                                         input logic [3:0] b);
    if (ic inside {4, 5, 6}) return b;
    if (ic inside {8, 9, 10, 11}) return 4'h4;
    return 4'hF;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] ic, e, m;
    logic [1:0] ns;
    ic = bus.opcode[7:4];
    if (reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= '0;
      m_cc   <= 3'b001;
      m_stat <= 2'b00;
    end else if (bus.commit && m_stat == 2'b00) begin
      ns = (ic > 11) ? 2'b10 : bus.mem_error ? 2'b11
         : (ic == 0) ? 2'b01 : 2'b00;
      m_stat <= ns;
      if (ns == 2'b00) begin
        e = (ic inside {2, 3, 6}) ? bus.rArB_wb[3:0]
          : (ic inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
        m = (ic inside {5, 11}) ? bus.rArB_wb[7:4] : 4'hF;
        if (e != 4'hF) m_reg[e] <= bus.valE;
        if (m != 4'hF) m_reg[m] <= bus.valM;
        if (ic == 6) m_cc <= bus.cc_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valA", bus.valA,
            m_rd(m_src_a(bus.opcode[7:4], bus.rArB[7:4])));
      check("valB", bus.valB,
            m_rd(m_src_b(bus.opcode[7:4], bus.rArB[3:0])));
      check("cc", 64'(bus.cc), 64'(m_cc));
      check("stat", 64'(bus.stat), 64'(m_stat));
      check("dbg_val", bus.dbg_val, m_rd(bus.dbg_sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] ab,
                       input logic [7:0] wb, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [2:0] cci,
                       input logic me);
    bus.opcode    = op;
    bus.rArB      = ab;
    bus.rArB_wb   = wb;
    bus.valE      = ve;
    bus.valM      = vm;
    bus.cc_in     = cci;
    bus.mem_error = me;
    bus.commit    = 1'b1;
    tick();
    bus.commit    = 1'b0;
    bus.mem_error = 1'b0;
  endtask

  task automatic peek(input string name, input logic [3:0] sel,
                      input logic [63:0] exp);
    pin     = 1'b1;
    pin_sel = sel;
    #1;
    check(name, bus.dbg_val, exp);
    pin     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.commit = 1'b1;
    bus.opcode = 8'h30;
    bus.rArB = 8'hF1;
    bus.rArB_wb = 8'hF1;
    bus.valE = 64'hDEAD;
    bus.valM = '0;
    bus.cc_in = 3'b000;
    bus.mem_error = 1'b0;
    tick();
    tick();
    bus.commit = 1'b0;
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_stat", 64'(bus.stat), 64'h0);
    check("rst_cc", 64'(bus.cc), 64'h1);
    peek("rst_over_commit_r1", 4'h1, 64'h0);

    issue(8'h30, 8'hF3, 8'hF3, 64'h1234, 0, 3'b000, 1'b0);
    peek("irmov_r3", 4'h3, 64'h1234);

    issue(8'h30, 8'hF5, 8'hF5, 64'h7, 0, 3'b000, 1'b0);
    issue(8'h22, 8'h25, 8'h2F, 64'h9, 0, 3'b000, 1'b0);
    peek("cmov_fail_r5", 4'h5, 64'h7);
    issue(8'h22, 8'h25, 8'h25, 64'h9, 0, 3'b000, 1'b0);
    peek("cmov_taken_r5", 4'h5, 64'h9);

    issue(8'h30, 8'hF4, 8'hF4, 64'h100, 0, 3'b000, 1'b0);
    bus.opcode = 8'hB0;
    bus.rArB = 8'h4F;
    bus.rArB_wb = 8'h4F;
    bus.valE = 64'h108;
    bus.valM = 64'hAA;
    bus.commit = 1'b1;
    #1;
    check("pop_valA", bus.valA, 64'h100);
    check("pop_valB", bus.valB, 64'h100);
    tick();
    bus.commit = 1'b0;
    peek("popq_rsp", 4'h4, 64'hAA);

    bus.opcode = 8'h61;
    bus.rArB = 8'h35;
    bus.rArB_wb = 8'h35;
    bus.valE = 64'h55;
    bus.cc_in = 3'b010;
    bus.commit = 1'b1;
    #1;
    check("opq_valA", bus.valA, 64'h1234);
    check("opq_valB", bus.valB, 64'h9);
    tick();
    bus.commit = 1'b0;
    check("opq_cc", 64'(bus.cc), 64'h2);
    peek("opq_r5", 4'h5, 64'h55);
    issue(8'h30, 8'hF1, 8'hF1, 64'h11, 0, 3'b111, 1'b0);
    check("cc_hold", 64'(bus.cc), 64'h2);
    peek("irmov_r1", 4'h1, 64'h11);

    issue(8'h30, 8'hFF, 8'hFF, 64'h77, 0, 3'b000, 1'b0);
    peek("dbg_rF", 4'hF, 64'h0);

    issue(8'h00, 8'hFF, 8'hFF, 64'h0, 0, 3'b000, 1'b0);
    check("halt_stat", 64'(bus.stat), 64'h1);
    issue(8'h30, 8'hF6, 8'hF6, 64'h5, 0, 3'b000, 1'b0);
    peek("halt_nowr_r6", 4'h6, 64'h0);
    issue(8'h61, 8'h35, 8'h35, 64'h1, 0, 3'b100, 1'b0);
    check("halt_cc", 64'(bus.cc), 64'h2);
    check("halt_sticky", 64'(bus.stat), 64'h1);
    do_reset();
    check("rst2_stat", 64'(bus.stat), 64'h0);
    check("rst2_cc", 64'(bus.cc), 64'h1);
    peek("rst2_r3", 4'h3, 64'h0);
    peek("rst2_r4", 4'h4, 64'h0);

    issue(8'hC0, 8'hF7, 8'hF7, 64'h5, 0, 3'b000, 1'b0);
    check("ins_stat", 64'(bus.stat), 64'h2);
    peek("ins_r7", 4'h7, 64'h0);
    do_reset();
    issue(8'h30, 8'hF2, 8'hF2, 64'h22, 0, 3'b000, 1'b0);
    issue(8'h50, 8'h23, 8'h23, 64'h0, 64'h99, 3'b000, 1'b1);
    check("adr_stat", 64'(bus.stat), 64'h3);
    peek("adr_r2", 4'h2, 64'h22);
    do_reset();
    issue(8'hC0, 8'hFF, 8'hFF, 64'h0, 0, 3'b000, 1'b1);
    check("ins_over_adr", 64'(bus.stat), 64'h2);
    do_reset();
    issue(8'h00, 8'hFF, 8'hFF, 64'h0, 0, 3'b000, 1'b1);
    check("adr_over_hlt", 64'(bus.stat), 64'h3);
    do_reset();
    issue(8'h50, 8'h23, 8'h23, 64'h0, 64'h99, 3'b000, 1'b0);
    peek("mrmov_r2", 4'h2, 64'h99);
    check("mrmov_stat", 64'(bus.stat), 64'h0);

    for (int i = 0; i < 20; i++) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
